// File: rtl/vend_change_dispenser.sv
// vend_change_dispenser: pays change as 10/5 coins through a hopper handshake, tracking inventory.
// Define CHANGE_AUDIT_EN to add the total_paid output (cumulative value paid, in 5-unit steps).
module vend_change_dispenser #(
    parameter int INV_W      = 6,
    parameter int INIT_INV5  = 10,
    parameter int INIT_INV10 = 10
) (
`ifdef CHANGE_AUDIT_EN
    output logic [15:0]      total_paid,
`endif
    input  logic             clk,
    input  logic             rst,
    input  logic             change_valid,
    input  logic [2:0]       change_amt,
    output logic             req_ready,
    output logic             coin_req,
    output logic             coin_sel,
    input  logic             coin_ack,
    input  logic             refill_valid,
    input  logic             refill_sel,
    input  logic [INV_W-1:0] refill_cnt,
    output logic [INV_W-1:0] inv5,
    output logic [INV_W-1:0] inv10,
    output logic             busy,
    output logic             done,
    output logic             err
);
    typedef enum logic [2:0] {IDLE, CHECK, REQ10, REQ5, GAP, DONE, ERR} state_t;

    state_t           state_q, state_d;
    logic [2:0]       amt_q, amt_d;
    logic [1:0]       rem10_q, rem10_d;
    logic [2:0]       rem5_q, rem5_d;
    logic [INV_W-1:0] inv5_q, inv5_d, inv10_q, inv10_d;
    logic [INV_W-1:0] half, t_w;
    logic [1:0]       t;
    logic [2:0]       f;
    logic [INV_W:0]   rsum;
    logic [INV_W-1:0] rsat;

    assign req_ready = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign coin_req  = state_q == REQ10 || state_q == REQ5;
    assign coin_sel  = state_q == REQ10;
    assign done      = state_q == DONE;
    assign err       = state_q == ERR;
    assign inv5      = inv5_q;
    assign inv10     = inv10_q;

    always_comb begin
        half    = INV_W'(amt_q[2:1]);
        t_w     = half < inv10_q ? half : inv10_q;
        t       = t_w[1:0];
        f       = amt_q - {t, 1'b0};
        rsum    = {1'b0, refill_sel ? inv10_q : inv5_q} + {1'b0, refill_cnt};
        rsat    = rsum[INV_W] ? '1 : rsum[INV_W-1:0];
        state_d = state_q;
        amt_d   = amt_q;
        rem10_d = rem10_q;
        rem5_d  = rem5_q;
        inv5_d  = inv5_q;
        inv10_d = inv10_q;
        case (state_q)
            IDLE: begin
                if (refill_valid && refill_sel) inv10_d = rsat;
                if (refill_valid && !refill_sel) inv5_d = rsat;
                if (change_valid) begin
                    amt_d   = change_amt;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (INV_W'(f) > inv5_q) state_d = ERR;
                else begin
                    rem10_d = t;
                    rem5_d  = f;
                    state_d = t != 2'd0 ? REQ10 : f != 3'd0 ? REQ5 : DONE;
                end
            end
            REQ10: if (coin_ack) begin
                inv10_d = inv10_q - INV_W'(1);
                rem10_d = rem10_q - 2'd1;
                state_d = GAP;
            end
            REQ5: if (coin_ack) begin
                inv5_d  = inv5_q - INV_W'(1);
                rem5_d  = rem5_q - 3'd1;
                state_d = GAP;
            end
            // all 10s drain before any 5 is requested
            GAP:     state_d = rem10_q != 2'd0 ? REQ10 : rem5_q != 3'd0 ? REQ5 : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            amt_q   <= '0;
            rem10_q <= '0;
            rem5_q  <= '0;
            inv5_q  <= INV_W'(INIT_INV5);
            inv10_q <= INV_W'(INIT_INV10);
        end else begin
            state_q <= state_d;
            amt_q   <= amt_d;
            rem10_q <= rem10_d;
            rem5_q  <= rem5_d;
            inv5_q  <= inv5_d;
            inv10_q <= inv10_d;
        end
    end

`ifdef CHANGE_AUDIT_EN
    logic [15:0] total_paid_q, total_paid_d;

    assign total_paid = total_paid_q;

    always_comb begin
        total_paid_d = total_paid_q;
        if (coin_ack && state_q == REQ10) total_paid_d = total_paid_q + 16'd2;
        if (coin_ack && state_q == REQ5) total_paid_d = total_paid_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) total_paid_q <= '0;
        else total_paid_q <= total_paid_d;
    end
`endif
endmodule
